// File: rtl/axi4_write_arbiter_if.sv
// Bus bundle for the N:1 AXI4-Stream write-data arbiter.
// master: arbiter side; slave: requesters plus FIFO side.
interface axi4_write_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 512,
   parameter int ID_W      = 2
);
   logic [NUM_PORTS*DATA_W-1:0] S_AXIS_TDATA;
   logic [NUM_PORTS-1:0]        S_AXIS_TVALID;
   logic [NUM_PORTS-1:0]        S_AXIS_TLAST;
   logic [NUM_PORTS-1:0]        S_AXIS_TREADY;
   logic [DATA_W-1:0]           M_AXIS_TDATA;
   logic                        M_AXIS_TVALID;
   logic                        M_AXIS_TLAST;
   logic [ID_W-1:0]             M_AXIS_TID;
   logic                        M_AXIS_TREADY;
   logic [NUM_PORTS-1:0]        GRANT;
   logic                        BUSY;

   modport master (
      input  S_AXIS_TDATA,
      input  S_AXIS_TVALID,
      input  S_AXIS_TLAST,
      output S_AXIS_TREADY,
      output M_AXIS_TDATA,
      output M_AXIS_TVALID,
      output M_AXIS_TLAST,
      output M_AXIS_TID,
      input  M_AXIS_TREADY,
      output GRANT,
      output BUSY
   );

   modport slave (
      output S_AXIS_TDATA,
      output S_AXIS_TVALID,
      output S_AXIS_TLAST,
      input  S_AXIS_TREADY,
      input  M_AXIS_TDATA,
      input  M_AXIS_TVALID,
      input  M_AXIS_TLAST,
      input  M_AXIS_TID,
      output M_AXIS_TREADY,
      input  GRANT,
      input  BUSY
   );
endinterface

// File: rtl/axi4_write_arbiter.sv
// Round-robin N:1 AXI4-Stream arbiter feeding the write-data FIFO.
// A grant lasts one burst: source TLAST or MAX_BURST beats.
module axi4_write_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int DATA_W    = 512,
   parameter int MAX_BURST = 16,
   parameter int ID_W      = 2
) (
   input logic clk,
   input logic rst_n,
   axi4_write_arbiter_if.master bus
);
   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = $clog2(MAX_BURST) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   state_t               state;
   logic [NUM_PORTS-1:0] grant;
   logic [IDX_W-1:0]     gidx;
   logic [IDX_W-1:0]     last;
   logic [ID_W-1:0]      tid;
   logic [CNT_W-1:0]     count;
   logic                 busy;

   logic [DATA_W-1:0]    port_data [NUM_PORTS];
   logic [IDX_W-1:0]     pick;
   logic [IDX_W-1:0]     cand;
   logic                 found;
   logic                 any_valid;
   logic                 out_valid;
   logic                 out_last;
   logic                 hs;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
      assign port_data[i] = bus.S_AXIS_TDATA[i*DATA_W +: DATA_W];
   end

   // First valid port after the previous winner, with wrap.
   always_comb begin
      pick  = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         cand = IDX_W'((int'(last) + k) % NUM_PORTS);
         if (!found && bus.S_AXIS_TVALID[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign any_valid = |bus.S_AXIS_TVALID;

   assign out_valid = busy && bus.S_AXIS_TVALID[gidx];
   assign out_last  = busy && (bus.S_AXIS_TLAST[gidx] ||
                               (count == CNT_MAX));
   assign hs        = out_valid && bus.M_AXIS_TREADY;

   assign bus.M_AXIS_TDATA  = port_data[gidx];
   assign bus.M_AXIS_TVALID = out_valid;
   assign bus.M_AXIS_TLAST  = out_last;
   assign bus.M_AXIS_TID    = tid;
   assign bus.S_AXIS_TREADY = grant & {NUM_PORTS{bus.M_AXIS_TREADY}};
   assign bus.GRANT         = grant;
   assign bus.BUSY          = busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         grant <= '0;
         gidx  <= '0;
         last  <= IDX_W'(NUM_PORTS - 1);
         tid   <= '0;
         count <= '0;
         busy  <= 1'b0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  state <= ST_GRANT;
                  grant <= NUM_PORTS'(1) << pick;
                  gidx  <= pick;
                  tid   <= ID_W'(pick);
                  count <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_GRANT: begin
               if (hs && out_last) begin
                  state <= ST_IDLE;
                  grant <= '0;
                  last  <= gidx;
                  count <= '0;
                  busy  <= 1'b0;
               end else if (hs) begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               grant <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_write_arbiter.sv
// Scoreboard bench for axi4_write_arbiter: directed bursts per port,
// expected beats queued on issue and checked by a handshake monitor.
module tb_axi4_write_arbiter;
   localparam int NP = 4;
   localparam int DW = 512;
   localparam int MB = 4;
   localparam int IW = 2;

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [DW-1:0] data;
      logic [IW-1:0] tid;
      logic          last;
   } exp_t;

   logic clk;
   logic rst_n;

   axi4_write_arbiter_if #(.NUM_PORTS(NP), .DATA_W(DW), .ID_W(IW)) bif ();

   axi4_write_arbiter #(
      .NUM_PORTS(NP),
      .DATA_W(DW),
      .MAX_BURST(MB),
      .ID_W(IW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bif)
   );

   beat_t         srcq [NP][$];
   exp_t          expq [$];
   logic [NP-1:0] hs_seen;
   logic [NP-1:0] hold;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            first_hs = -1;
   int            last_hs = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic push_src(int p, logic [DW-1:0] d, logic l);
      beat_t b;
      b.data = d;
      b.last = l;
      srcq[p].push_back(b);
   endtask

   task automatic push_exp(logic [DW-1:0] d, logic [IW-1:0] t, logic l);
      exp_t e;
      e.data = d;
      e.tid  = t;
      e.last = l;
      expq.push_back(e);
   endtask

   function automatic int pending();
      int n;
      n = expq.size();
      for (int i = 0; i < NP; i++) n += srcq[i].size();
      return n;
   endfunction

   task automatic drain(string nm, int budget);
      int n;
      n = 0;
      while (pending() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_drain_left"}, DW'(pending()), '0);
      repeat (2) @(negedge clk);
   endtask

   // Requester model: present queue head, pop after an observed handshake.
   always @(negedge clk)
      hs_seen = bif.S_AXIS_TVALID & bif.S_AXIS_TREADY;

   initial begin
      bif.S_AXIS_TDATA  = '0;
      bif.S_AXIS_TVALID = '0;
      bif.S_AXIS_TLAST  = '0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (hs_seen[i] && srcq[i].size() > 0)
               void'(srcq[i].pop_front());
            if (srcq[i].size() > 0 && !hold[i]) begin
               bif.S_AXIS_TVALID[i] = 1'b1;
               bif.S_AXIS_TDATA[i*DW +: DW] = srcq[i][0].data;
               bif.S_AXIS_TLAST[i] = srcq[i][0].last;
            end else begin
               bif.S_AXIS_TVALID[i] = 1'b0;
               bif.S_AXIS_TLAST[i]  = 1'b0;
            end
         end
      end
   end

   // Monitor: every output handshake must match the scoreboard head.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bif.M_AXIS_TVALID && bif.M_AXIS_TREADY) begin
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         if (expq.size() == 0) begin
            chk("unexpected_beat", bif.M_AXIS_TDATA, '1);
         end else begin
            e = expq.pop_front();
            chk("beat_data", bif.M_AXIS_TDATA, e.data);
            chk("beat_tid", DW'(bif.M_AXIS_TID), DW'(e.tid));
            chk("beat_last", DW'(bif.M_AXIS_TLAST), DW'(e.last));
            chk("beat_grant", DW'(bif.GRANT), DW'(NP'(1) << e.tid));
            chk("beat_tready", DW'(bif.S_AXIS_TREADY), DW'(bif.GRANT));
            chk("beat_busy", DW'(bif.BUSY), DW'(1));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      hold = '0;
      hs_seen = '0;
      bif.M_AXIS_TREADY = 1'b1;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_grant", DW'(bif.GRANT), '0);
      chk("rst_busy", DW'(bif.BUSY), '0);
      chk("rst_tvalid", DW'(bif.M_AXIS_TVALID), '0);
      chk("rst_tlast", DW'(bif.M_AXIS_TLAST), '0);
      chk("rst_tid", DW'(bif.M_AXIS_TID), '0);
      chk("rst_tready", DW'(bif.S_AXIS_TREADY), '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single port 1, three beats; pointer 3 -> 1
      for (int b = 0; b < 3; b++) begin
         push_src(1, DW'(8'hA0 + b), b == 2);
         push_exp(DW'(8'hA0 + b), 2'd1, b == 2);
      end
      @(negedge clk);
      chk("t1_bubble_tvalid", DW'(bif.M_AXIS_TVALID), '0);
      chk("t1_bubble_grant", DW'(bif.GRANT), '0);
      chk("t1_bubble_tready", DW'(bif.S_AXIS_TREADY), '0);
      @(negedge clk);
      chk("t1_grant", DW'(bif.GRANT), DW'(4'b0010));
      chk("t1_tid", DW'(bif.M_AXIS_TID), DW'(1));
      chk("t1_b0", bif.M_AXIS_TDATA, DW'(8'hA0));
      @(negedge clk);
      chk("t1_b1", bif.M_AXIS_TDATA, DW'(8'hA1));
      chk("t1_b1_last", DW'(bif.M_AXIS_TLAST), '0);
      @(negedge clk);
      chk("t1_b2", bif.M_AXIS_TDATA, DW'(8'hA2));
      chk("t1_b2_last", DW'(bif.M_AXIS_TLAST), DW'(1));
      @(negedge clk);
      chk("t1_idle_grant", DW'(bif.GRANT), '0);
      chk("t1_idle_busy", DW'(bif.BUSY), '0);
      drain("t1", 50);

      // All ports, one-beat bursts; pointer at 1 so order 2,3,0,1,...
      first_hs = -1;
      for (int i = 0; i < NP; i++) begin
         push_src(i, DW'(8'hB0 + i), 1'b1);
         push_src(i, DW'(8'hC0 + i), 1'b1);
      end
      push_exp(DW'(8'hB2), 2'd2, 1'b1);
      push_exp(DW'(8'hB3), 2'd3, 1'b1);
      push_exp(DW'(8'hB0), 2'd0, 1'b1);
      push_exp(DW'(8'hB1), 2'd1, 1'b1);
      push_exp(DW'(8'hC2), 2'd2, 1'b1);
      push_exp(DW'(8'hC3), 2'd3, 1'b1);
      push_exp(DW'(8'hC0), 2'd0, 1'b1);
      push_exp(DW'(8'hC1), 2'd1, 1'b1);
      drain("t2", 100);
      chk("t2_span", DW'(last_hs - first_hs), DW'(14));

      // Port 2, ten beats: MAX_BURST cuts at beats 4 and 8
      first_hs = -1;
      for (int b = 0; b < 10; b++) begin
         push_src(2, DW'(8'hD0 + b), b == 9);
         push_exp(DW'(8'hD0 + b), 2'd2, (b == 3) || (b == 7) || (b == 9));
      end
      drain("t3", 100);
      chk("t3_span", DW'(last_hs - first_hs), DW'(11));

      // Port 0 under back-pressure while port 3 waits
      for (int b = 0; b < 3; b++) begin
         push_src(0, DW'(8'hE0 + b), b == 2);
         push_exp(DW'(8'hE0 + b), 2'd0, b == 2);
      end
      push_exp(DW'(8'hF0), 2'd3, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("t4_grant0", DW'(bif.GRANT), DW'(4'b0001));
      push_src(3, DW'(8'hF0), 1'b1);
      for (int r = 0; r < 2; r++) begin
         @(posedge clk);
         #1 bif.M_AXIS_TREADY = 1'b0;
         @(negedge clk);
         chk("t4_hold_data", bif.M_AXIS_TDATA, DW'(8'hE1));
         chk("t4_hold_tid", DW'(bif.M_AXIS_TID), '0);
         chk("t4_hold_valid", DW'(bif.M_AXIS_TVALID), DW'(1));
         chk("t4_hold_grant", DW'(bif.GRANT), DW'(4'b0001));
         chk("t4_hold_tready", DW'(bif.S_AXIS_TREADY), '0);
         chk("t4_p3_waiting", DW'(bif.S_AXIS_TVALID[3]), DW'(1));
      end
      @(posedge clk);
      #1 bif.M_AXIS_TREADY = 1'b1;
      drain("t4", 50);

      // Port 1 drops TVALID mid-burst while port 2 waits
      for (int b = 0; b < 3; b++) begin
         push_src(1, DW'(8'h60 + b), b == 2);
         push_exp(DW'(8'h60 + b), 2'd1, b == 2);
      end
      push_exp(DW'(8'h70), 2'd2, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk("t5_grant1", DW'(bif.GRANT), DW'(4'b0010));
      push_src(2, DW'(8'h70), 1'b1);
      hold[1] = 1'b1;
      for (int r = 0; r < 3; r++) begin
         @(negedge clk);
         chk("t5_gap_grant", DW'(bif.GRANT), DW'(4'b0010));
         chk("t5_gap_tvalid", DW'(bif.M_AXIS_TVALID), '0);
         chk("t5_gap_tready", DW'(bif.S_AXIS_TREADY), DW'(4'b0010));
      end
      hold[1] = 1'b0;
      drain("t5", 50);

      // Asynchronous reset after beat 2 of a five-beat burst
      for (int b = 0; b < 5; b++)
         push_src(0, DW'(8'h80 + b), b == 4);
      push_exp(DW'(8'h80), 2'd0, 1'b0);
      push_exp(DW'(8'h81), 2'd0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_tvalid", DW'(bif.M_AXIS_TVALID), '0);
      chk("t6_async_grant", DW'(bif.GRANT), '0);
      chk("t6_async_tready", DW'(bif.S_AXIS_TREADY), '0);
      chk("t6_async_busy", DW'(bif.BUSY), '0);
      chk("t6_beats_seen", DW'(expq.size()), '0);
      for (int i = 0; i < NP; i++) srcq[i].delete();
      expq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      push_src(0, DW'(8'h90), 1'b1);
      push_src(1, DW'(8'h91), 1'b1);
      push_exp(DW'(8'h90), 2'd0, 1'b1);
      push_exp(DW'(8'h91), 2'd1, 1'b1);
      drain("t6", 50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
